mul_seq: RTL and testbench
==========================

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, operand FIFO entries, power of two, 2..16.
REQ-002 clk_i  input  1  single clock, all state on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 a_bi  input  8  operand A to enqueue.
REQ-005 b_bi  input  8  operand B to enqueue.
REQ-006 push_i  input  1  enqueue {a_bi,b_bi} this cycle.
REQ-007 full_o  output  1  FIFO full; pushes ignored.
REQ-008 mul_a_bo  output  8  operand A to multiplier a_bi.
REQ-009 mul_b_bo  output  8  operand B to multiplier b_bi.
REQ-010 mul_start_o  output  1  multiplier start_i.
REQ-011 mul_busy_i  input  1  multiplier busy_o.
REQ-012 mul_y_bi  input  16  multiplier y_bo.
REQ-013 y_bo  output  16  captured product.
REQ-014 valid_o  output  1  y_bo holds an unacknowledged product.
REQ-015 ack_i  input  1  consumer accepts y_bo.

Function
REQ-016 FIFO: push_i with full_o=0 writes entry at write pointer; pointers wrap modulo FIFO_DEPTH; count register 0..FIFO_DEPTH; full_o = (count==FIFO_DEPTH), combinational from count.
REQ-017 Push while full: dropped, no state change; push and pop same cycle on non-empty FIFO: count unchanged.
REQ-018 FSM states IDLE, ISSUE, WAIT_HI, WAIT_LO, HOLD.
REQ-019 IDLE: if count>0 and mul_busy_i=0, pop head into mul_a_bo/mul_b_bo registers, go ISSUE.
REQ-020 ISSUE: mul_start_o=1 for exactly this one cycle, go WAIT_HI; operands held stable until WAIT_LO exit.
REQ-021 WAIT_HI: stay until mul_busy_i=1, then WAIT_LO.
REQ-022 WAIT_LO: on mul_busy_i=0, load y_bo<=mul_y_bi, set valid_o, go HOLD.
REQ-023 HOLD: valid_o=1, y_bo stable; on ack_i=1 clear valid_o next edge, go IDLE; next issue no earlier than the cycle after.
REQ-024 ack_i while valid_o=0: ignored.
REQ-025 Pipeline: FIFO accepts pushes in every state; operands compute in order, one product outstanding.
REQ-026 Latency push-to-start (empty FIFO, idle multiplier): start asserted 2 cycles after push edge.

Reset
REQ-027 rst_i=0 asynchronously: FSM=IDLE, pointers/count=0, full_o=0, mul_start_o=0, mul_a_bo=mul_b_bo=0, y_bo=0, valid_o=0; FIFO contents undefined.
REQ-028 Reset mid-operation discards queued and in-flight operands; multiplier is reset by its own reset, no result captured.
REQ-029 After rst_i release, first IDLE decision on the second rising edge.

Configuration
REQ-030 Macro MUL_SEQ_ACC_EN defined: adds output acc_bo (24 bits) and input clr_i (1); acc_bo += mul_y_bi on every WAIT_LO capture, zero on reset; clr_i=1 zeroes acc_bo, capture same cycle loads mul_y_bi alone; wrap modulo 2^24.
REQ-031 Macro undefined: acc_bo and clr_i absent, no accumulator logic.

Verification
REQ-032 Reset, push (3,5), ack when valid -> mul_start_o one pulse, y_bo=15, valid_o until ack.
REQ-033 Push 5 pairs back-to-back, FIFO_DEPTH=4, no ack -> full_o=1 after 4th, 5th dropped; acking 4 yields 0,1,4,9 for pairs (0,0)..(3,3).
REQ-034 Push (255,255) -> y_bo=65025; valid_o held 20 cycles without ack, y_bo stable, no second start.
REQ-035 Push (7,9), rst_i=0 during WAIT_LO -> all outputs reset, valid_o never asserts, FIFO empty.
REQ-036 MUL_SEQ_ACC_EN: products 10,20,30 -> acc_bo=60; clr_i then product 4 -> acc_bo=4.
REQ-037 Push and ack simultaneous with FIFO count 2 -> count stays consistent, order preserved.

Source files
------------

// File: rtl/mul_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq_if
//  Brief    : Operand-queue, multiplier-handshake and result signals of mul_seq.
//             MUL_SEQ_ACC_EN adds the accumulator output and its clear input.
//  Revision : 1.0  initial release
// ============================================================================
interface mul_seq_if;
  logic [7:0]  a_bi;
  logic [7:0]  b_bi;
  logic        push_i;
  logic        full_o;
  logic [7:0]  mul_a_bo;
  logic [7:0]  mul_b_bo;
  logic        mul_start_o;
  logic        mul_busy_i;
  logic [15:0] mul_y_bi;
  logic [15:0] y_bo;
  logic        valid_o;
  logic        ack_i;
`ifdef MUL_SEQ_ACC_EN
  logic [23:0] acc_bo;
  logic        clr_i;
`endif

  modport slave (
    input  a_bi, b_bi, push_i, mul_busy_i, mul_y_bi, ack_i,
    output full_o, mul_a_bo, mul_b_bo, mul_start_o, y_bo, valid_o
`ifdef MUL_SEQ_ACC_EN
    , input clr_i, output acc_bo
`endif
  );

  modport master (
    output a_bi, b_bi, push_i, mul_busy_i, mul_y_bi, ack_i,
    input  full_o, mul_a_bo, mul_b_bo, mul_start_o, y_bo, valid_o
`ifdef MUL_SEQ_ACC_EN
    , output clr_i, input acc_bo
`endif
  );
endinterface
`default_nettype wire

// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq
//  Brief    : Operand FIFO feeding an external sequential multiplier, one
//             product outstanding; optional accumulator via MUL_SEQ_ACC_EN.
//  Revision : 1.0  initial release
// ============================================================================
module mul_seq #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  mul_seq_if.slave   bus
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_ISSUE   = 3'd1;
  localparam logic [2:0] c_WAIT_HI = 3'd2;
  localparam logic [2:0] c_WAIT_LO = 3'd3;
  localparam logic [2:0] c_HOLD    = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic               r_run;
  logic [15:0]        r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [7:0]         r_mul_a;
  logic [7:0]         r_mul_b;
  logic [15:0]        r_y;
  logic [15:0]        w_head;
  logic               w_full;
  logic               w_push;
  logic               w_can_issue;
  logic               w_pop;
  logic               w_capture;
  logic               w_start;
  logic               w_valid;

  assign w_full      = (r_count == c_FULL_CNT);
  assign w_push      = bus.push_i && !w_full;
  assign w_head      = r_mem[r_rd_ptr];
  // r_run holds off the first issue decision until the second edge after reset release
  assign w_can_issue = r_run && (r_count != '0) && !bus.mul_busy_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= c_IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:    if (w_can_issue)       w_next_state = c_ISSUE;
      c_ISSUE:                          w_next_state = c_WAIT_HI;
      c_WAIT_HI: if (bus.mul_busy_i)    w_next_state = c_WAIT_LO;
      c_WAIT_LO: if (!bus.mul_busy_i)   w_next_state = c_HOLD;
      c_HOLD:    if (bus.ack_i)         w_next_state = c_IDLE;
      default:                          w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_start   = 1'b0;
    w_valid   = 1'b0;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      c_IDLE:    w_pop     = w_can_issue;
      c_ISSUE:   w_start   = 1'b1;
      c_WAIT_LO: w_capture = !bus.mul_busy_i;
      c_HOLD:    w_valid   = 1'b1;
      default:   ;
    endcase
  end

  // Storage has no reset: stale entries are never read because count gates pops
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.a_bi, bus.b_bi};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_y     <= '0;
    end else begin
      if (w_pop) begin
        r_mul_a <= w_head[15:8];
        r_mul_b <= w_head[7:0];
      end
      if (w_capture) begin
        r_y <= bus.mul_y_bi;
      end
    end
  end

`ifdef MUL_SEQ_ACC_EN
  logic [23:0] r_acc;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_acc <= '0;
    end else if (w_capture) begin
      r_acc <= bus.clr_i ? 24'(bus.mul_y_bi) : r_acc + 24'(bus.mul_y_bi);
    end else if (bus.clr_i) begin
      r_acc <= '0;
    end
  end

  assign bus.acc_bo = r_acc;
`endif

  assign bus.full_o      = w_full;
  assign bus.mul_a_bo    = r_mul_a;
  assign bus.mul_b_bo    = r_mul_b;
  assign bus.mul_start_o = w_start;
  assign bus.y_bo        = r_y;
  assign bus.valid_o     = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_seq
//  Brief    : Directed self-checking bench for mul_seq with a behavioural
//             multi-cycle multiplier; MUL_SEQ_ACC_EN enables accumulator steps.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_seq;
  logic clk;
  logic rst_n;
  logic force_busy;
  int   n_checks;
  int   n_errors;
  int   n_starts;

  mul_seq_if u_if ();

  mul_seq #(.FIFO_DEPTH(4)) u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier: busy rises the edge after start, product appears as busy falls
  logic        r_mbusy;
  logic [1:0]  r_mcnt;
  logic [15:0] r_mprod;
  logic [15:0] r_my;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mbusy <= 1'b0;
      r_mcnt  <= 2'd0;
      r_mprod <= 16'd0;
      r_my    <= 16'd0;
    end else if (!r_mbusy) begin
      if (u_if.mul_start_o) begin
        r_mbusy <= 1'b1;
        r_mcnt  <= 2'd2;
        r_mprod <= 16'(u_if.mul_a_bo) * 16'(u_if.mul_b_bo);
      end
    end else if (r_mcnt == 2'd1) begin
      r_mbusy <= 1'b0;
      r_my    <= r_mprod;
    end else begin
      r_mcnt <= r_mcnt - 2'd1;
    end
  end

  assign u_if.mul_busy_i = r_mbusy | force_busy;
  assign u_if.mul_y_bi   = r_my;

  always @(posedge clk) begin
    if (u_if.mul_start_o) n_starts++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    u_if.a_bi   = a;
    u_if.b_bi   = b;
    u_if.push_i = 1'b1;
    @(negedge clk);
    u_if.push_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!u_if.valid_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid"}, 32'(u_if.valid_o), 32'd1);
  endtask

  task automatic do_ack(input string tag);
    u_if.ack_i = 1'b1;
    @(negedge clk);
    u_if.ack_i = 1'b0;
    chk({tag, "_ackclr"}, 32'(u_if.valid_o), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    push(a, b);
    wait_valid(tag);
    chk({tag, "_y"}, 32'(u_if.y_bo), 32'(exp));
    do_ack(tag);
  endtask

  initial begin
    int   s0;
    logic seen;
    logic [15:0] exp_q [5];
    n_checks = 0;
    n_errors = 0;
    n_starts = 0;
    force_busy  = 1'b0;
    rst_n       = 1'b0;
    u_if.a_bi   = 8'd0;
    u_if.b_bi   = 8'd0;
    u_if.push_i = 1'b0;
    u_if.ack_i  = 1'b0;
`ifdef MUL_SEQ_ACC_EN
    u_if.clr_i  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_full",  32'(u_if.full_o),      32'd0);
    chk("rst_start", 32'(u_if.mul_start_o), 32'd0);
    chk("rst_mula",  32'(u_if.mul_a_bo),    32'd0);
    chk("rst_mulb",  32'(u_if.mul_b_bo),    32'd0);
    chk("rst_y",     32'(u_if.y_bo),        32'd0);
    chk("rst_valid", 32'(u_if.valid_o),     32'd0);
`ifdef MUL_SEQ_ACC_EN
    chk("rst_acc",   32'(u_if.acc_bo),      32'd0);
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single product with start-pulse latency and width
    s0 = n_starts;
    push(8'd3, 8'd5);
    chk("lat_start_e1", 32'(u_if.mul_start_o), 32'd0);
    @(negedge clk);
    chk("lat_start_e2", 32'(u_if.mul_start_o), 32'd1);
    chk("op_a",         32'(u_if.mul_a_bo),    32'd3);
    chk("op_b",         32'(u_if.mul_b_bo),    32'd5);
    @(negedge clk);
    chk("lat_start_e3", 32'(u_if.mul_start_o), 32'd0);
    wait_valid("p35");
    chk("p35_y", 32'(u_if.y_bo), 32'd15);
    repeat (3) @(negedge clk);
    chk("p35_hold", 32'(u_if.valid_o), 32'd1);
    do_ack("p35");
    chk("p35_starts", 32'(n_starts - s0), 32'd1);

    // Fill the FIFO while the multiplier reports busy; the fifth push is dropped
    force_busy = 1'b1;
    s0 = n_starts;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) chk("fill_full4", 32'(u_if.full_o), 32'd1);
      else        chk("fill_notfull", 32'(u_if.full_o), 32'd0);
      u_if.a_bi   = 8'(i);
      u_if.b_bi   = 8'(i);
      u_if.push_i = 1'b1;
    end
    @(negedge clk);
    u_if.push_i = 1'b0;
    chk("fill_full5", 32'(u_if.full_o), 32'd1);
    force_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_valid("fill");
      chk("fill_y", 32'(u_if.y_bo), 32'(i * i));
      do_ack("fill");
    end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | u_if.valid_o;
    end
    chk("fill_drop5", 32'(seen), 32'd0);
    chk("fill_starts", 32'(n_starts - s0), 32'd4);
    chk("fill_empty", 32'(u_if.full_o), 32'd0);

    // Ack while nothing is valid must not disturb the next result
    u_if.ack_i = 1'b1;
    repeat (2) @(negedge clk);
    u_if.ack_i = 1'b0;

    // Maximum operands, long hold without ack
    s0 = n_starts;
    push(8'd255, 8'd255);
    wait_valid("max");
    chk("max_y", 32'(u_if.y_bo), 32'd65025);
    seen = 1'b1;
    repeat (20) begin
      @(negedge clk);
      seen = seen & u_if.valid_o & (u_if.y_bo == 16'd65025);
    end
    chk("max_hold20", 32'(seen), 32'd1);
    chk("max_starts", 32'(n_starts - s0), 32'd1);
    do_ack("max");

    // Reset while the product is in flight
    push(8'd7, 8'd9);
    begin
      int k = 0;
      while (!u_if.mul_busy_i && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    chk("mrst_busy", 32'(u_if.mul_busy_i), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_mula",  32'(u_if.mul_a_bo),    32'd0);
    chk("mrst_mulb",  32'(u_if.mul_b_bo),    32'd0);
    chk("mrst_y",     32'(u_if.y_bo),        32'd0);
    chk("mrst_start", 32'(u_if.mul_start_o), 32'd0);
    chk("mrst_valid", 32'(u_if.valid_o),     32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s0 = n_starts;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | u_if.valid_o;
    end
    chk("mrst_novalid", 32'(seen), 32'd0);
    chk("mrst_nostart", 32'(n_starts - s0), 32'd0);
    chk("mrst_full",    32'(u_if.full_o), 32'd0);

    // Push coinciding with ack at count 2, then push coinciding with pop
    push(8'd1, 8'd1);
    wait_valid("pa");
    chk("pa_y0", 32'(u_if.y_bo), 32'd1);
    push(8'd2, 8'd3);
    push(8'd4, 8'd5);
    u_if.ack_i  = 1'b1;
    u_if.a_bi   = 8'd6;
    u_if.b_bi   = 8'd7;
    u_if.push_i = 1'b1;
    @(negedge clk);
    u_if.ack_i  = 1'b0;
    chk("pa_ackclr", 32'(u_if.valid_o), 32'd0);
    u_if.a_bi   = 8'd8;
    u_if.b_bi   = 8'd9;
    @(negedge clk);
    chk("pa_cnt3", 32'(u_if.full_o), 32'd0);
    u_if.a_bi   = 8'd10;
    u_if.b_bi   = 8'd11;
    @(negedge clk);
    u_if.push_i = 1'b0;
    chk("pa_cnt4", 32'(u_if.full_o), 32'd1);
    exp_q = '{16'd6, 16'd20, 16'd42, 16'd72, 16'd110};
    for (int i = 0; i < 5; i++) begin
      wait_valid("pa");
      chk("pa_y", 32'(u_if.y_bo), 32'(exp_q[i]));
      do_ack("pa");
    end
    chk("pa_empty", 32'(u_if.full_o), 32'd0);

`ifdef MUL_SEQ_ACC_EN
    @(negedge clk);
    u_if.clr_i = 1'b1;
    @(negedge clk);
    u_if.clr_i = 1'b0;
    chk("acc_clr0", 32'(u_if.acc_bo), 32'd0);
    run_op("acc10", 8'd2, 8'd5, 16'd10);
    run_op("acc20", 8'd4, 8'd5, 16'd20);
    run_op("acc30", 8'd5, 8'd6, 16'd30);
    chk("acc_sum60", 32'(u_if.acc_bo), 32'd60);
    u_if.clr_i = 1'b1;
    @(negedge clk);
    u_if.clr_i = 1'b0;
    chk("acc_clr1", 32'(u_if.acc_bo), 32'd0);
    run_op("acc4", 8'd1, 8'd4, 16'd4);
    chk("acc_sum4", 32'(u_if.acc_bo), 32'd4);
`else
    run_op("tail", 8'd12, 8'd13, 16'd156);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
